nn_argmax: RTL

NN_ARGMAX -- requirements
Module: nn_argmax

---
 rtl/nn_argmax_pkg.sv | 18 +
 rtl/nn_argmax_if.sv | 30 +++
 rtl/nn_argmax_cmp.sv | 21 ++
 rtl/nn_argmax.sv | 110 +++++++++++
 4 files changed

// File: rtl/nn_argmax_pkg.sv
// rtl/nn_argmax_pkg.sv - shared defaults, state encoding and index-width helper for nn_argmax
package nn_pkg;

  localparam int NN_NUM_CLASSES = 10;
  localparam int NN_DATA_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_e;

  // Class index width; a single class still needs a one-bit index port.
  function automatic int idx_width(input int num_classes);
    return (num_classes > 1) ? $clog2(num_classes) : 1;
  endfunction

endpackage

// File: rtl/nn_argmax_if.sv
// rtl/nn_argmax_if.sv - score input / argmax result handshake bundle
interface nn_argmax_if #(
  parameter int NUM_CLASSES = nn_pkg::NN_NUM_CLASSES,
  parameter int DATA_WIDTH  = nn_pkg::NN_DATA_WIDTH
) ();
  import nn_pkg::*;

  localparam int IDX_W = idx_width(NUM_CLASSES);

  logic [NUM_CLASSES-1:0]            in_valid;
  logic [NUM_CLASSES*DATA_WIDTH-1:0] in_data;
  logic                              out_ready;
  logic                              out_valid;
  logic [IDX_W-1:0]                  out_class;
  logic [DATA_WIDTH-1:0]             out_score;
  logic                              busy;

  // Producer of scores and consumer of the result.
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_class, out_score, busy
  );

  // The argmax engine.
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_class, out_score, busy
  );

endinterface

// File: rtl/nn_argmax_cmp.sv
// rtl/nn_argmax_cmp.sv - signed compare-select; ties keep the incumbent
module nn_argmax_cmp #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 4
) (
  input  logic [DATA_WIDTH-1:0] i_best_score,
  input  logic [IDX_W-1:0]      i_best_idx,
  input  logic [DATA_WIDTH-1:0] i_cand_score,
  input  logic [IDX_W-1:0]      i_cand_idx,
  output logic [DATA_WIDTH-1:0] o_score,
  output logic [IDX_W-1:0]      o_idx
);

  logic w_take;

  // Strictly greater replaces, so an equal later score never displaces a lower index.
  assign w_take  = $signed(i_cand_score) > $signed(i_best_score);
  assign o_score = w_take ? i_cand_score : i_best_score;
  assign o_idx   = w_take ? i_cand_idx   : i_best_idx;

endmodule

// File: rtl/nn_argmax.sv
// rtl/nn_argmax.sv - sequential argmax over one captured score vector; NN_ARGMAX_DROP_CNT_EN adds drop_cnt
module nn_argmax
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = NN_NUM_CLASSES,
  parameter int DATA_WIDTH  = NN_DATA_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  nn_argmax_if.slave  bus
`ifdef NN_ARGMAX_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);

  localparam int               IDX_W    = idx_width(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0] FIRST_SCAN_IDX = IDX_W'((NUM_CLASSES > 1) ? 1 : 0);

  argmax_state_e                     r_state;
  argmax_state_e                     w_next;
  logic [NUM_CLASSES*DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0]             r_best_score;
  logic [IDX_W-1:0]                  r_best_idx;
  logic [IDX_W-1:0]                  r_idx;
  logic                              w_all_valid;
  logic                              w_busy;
  logic [DATA_WIDTH-1:0]             w_cand;
  logic [DATA_WIDTH-1:0]             w_cmp_score;
  logic [IDX_W-1:0]                  w_cmp_idx;

  assign w_all_valid = &bus.in_valid;
  assign w_busy      = (r_state != IDLE);
  assign w_cand      = r_hold[r_idx*DATA_WIDTH +: DATA_WIDTH];

  nn_argmax_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_cmp (
    .i_best_score (r_best_score),
    .i_best_idx   (r_best_idx),
    .i_cand_score (w_cand),
    .i_cand_idx   (r_idx),
    .o_score      (w_cmp_score),
    .o_idx        (w_cmp_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state: capture only a complete vector, scan to the last class, hold until consumed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_all_valid) w_next = (NUM_CLASSES == 1) ? DONE : SCAN;
      SCAN: if (r_idx == LAST_IDX) w_next = DONE;
      DONE: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: hold register, running best and scan index; frozen outside capture and scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold       <= '0;
      r_best_score <= '0;
      r_best_idx   <= '0;
      r_idx        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_all_valid) begin
            r_hold       <= bus.in_data;
            r_best_score <= bus.in_data[DATA_WIDTH-1:0];
            r_best_idx   <= '0;
            r_idx        <= FIRST_SCAN_IDX;
          end
        end
        SCAN: begin
          r_best_score <= w_cmp_score;
          r_best_idx   <= w_cmp_idx;
          r_idx        <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = (r_state == DONE);
  assign bus.out_class = r_best_idx;
  assign bus.out_score = r_best_score;
  assign bus.busy      = w_busy;

`ifdef NN_ARGMAX_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  // Count complete vectors that arrive while busy, saturating at 255.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                            r_drop_cnt <= '0;
    else if (w_all_valid && w_busy && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule
